spi_sample_display: RTL and testbench
=====================================

Name: spi_sample_display

Overview:
Downstream consumer of the SPI read stage. Captures each 16-bit word that the SPI reader marks ready and converts its sample field from binary to 4-digit BCD with a sequential double-dabble. Drives a multiplexed 4-digit common-anode 7-segment display (Basys3-style) with the result. Replaces the raw LED dump in the board top.

Parameters:
SAMPLE_W, 12, sample field width taken from d[SAMPLE_W-1:0]; legal 1..13, so the result fits 4 BCD digits.
REFRESH_DIV, 100_000, clk cycles per digit slot (1 kHz per digit at 100 MHz).
BLANK_LZ, 1, 1 blanks leading zero digits; digit 0 is never blanked.

Ports:
clk  in  1  system clock
rst_l  in  1  asynchronous active-low reset
d  in  16  SPI word; stable while d_ready=1
d_ready  in  1  level from SPI reader, high while d is valid; may come from another clock domain
seg  out  7  {g,f,e,d,c,b,a}, active-low
dp  out  1  decimal point, active-low; constant 1 (off)
an  out  4  digit enables, active-low one-hot; an[0] is the rightmost digit
bcd  out  16  last converted value, 4 BCD nibbles, digit 3 in [15:12]
bcd_valid  out  1  one-cycle pulse when bcd updates
overrun  out  1  sticky; set when a pending sample is overwritten

Behaviour:
- Reset (async, rst_l=0): bcd=0, bcd_valid=0, overrun=0, FSM=IDLE, pending empty, digit_sel=0, refresh count=0.
  - Display outputs in reset: an=4'b1110, seg=7'b1000000 ("0"), dp=1.
  - A reset during SHIFT aborts the conversion; no bcd_valid is produced.
- Input capture:
  - d_ready passes through a 2-flop synchronizer; a rising edge is detected against a third flop.
  - On the detected edge, pending <= d[SAMPLE_W-1:0] and pending_v <= 1. Bits above SAMPLE_W-1 are ignored.
  - If pending_v is already 1 and not being consumed in the same cycle, overrun <= 1 and the newer sample overwrites pending.
  - Edge detection and consumption in the same cycle: the new sample is stored and pending_v stays 1, with no overrun.
- Conversion FSM:
  - IDLE: if pending_v, load shifter {bcd_acc=0, bin=pending}, clear pending_v, cnt=0, go to SHIFT.
  - SHIFT: each cycle, add 3 to every BCD nibble >=5, then shift {bcd_acc,bin} left by 1, cnt++. After the SAMPLE_W-th shift, go to DONE.
  - DONE: bcd <= bcd_acc, bcd_valid=1 for exactly this cycle, then go to IDLE.
- Latency, idle block, edge numbering from the first clk edge that samples d_ready=1:
  - edge 3: capture into pending
  - edge 4: load shifter
  - edges 5..SAMPLE_W+4: shifts
  - bcd_valid=1 after edge SAMPLE_W+5 (17 for the default)
- Throughput: one conversion per SAMPLE_W+2 cycles. Pending is one deep; the newest sample wins.
- Display scan:
  - Refresh counter runs 0..REFRESH_DIV-1 continuously.
  - On wrap, digit_sel advances 0→1→2→3→0, and an = ~(1<<digit_sel).
  - seg is the decode of bcd nibble[digit_sel]; all outputs are registered.
  - Blanking: with BLANK_LZ=1, digit k>0 shows seg=7'b1111111 when nibbles k..3 are all zero.
  - The display changes only when bcd changes, never mid-conversion.
- Decode, active-low, digits 0-9: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000. Nibbles above 9 (unreachable) display 0111111 ("-").

Decomposition:
- Package spi_disp_pkg: FSM state encoding (IDLE, SHIFT, DONE), the 7-segment digit constants and blank/dash patterns, and the digit count 4.
- Sub-module bin2bcd_seq: the double-dabble shifter, counter and FSM, with a start/done interface.
- Capture, synchronizer and scan logic stay in spi_sample_display.

Test Plan:
1. Reset: hold rst_l=0 → an=1110, seg=1000000, dp=1, bcd=0, bcd_valid=0, overrun=0. Release: digit 0 shows "0" and digits 1-3 are blank.
2. Conversion: d=16'h0FFF, raise d_ready → bcd=16'h4095 with a single bcd_valid pulse 17 cycles after d_ready is first sampled.
3. Upper-bit masking: d=16'hF07B → bcd=16'h0123, unchanged by bits [15:12].
4. Scan (REFRESH_DIV=4) holding 0x0123: an steps 1110→1101→1011→0111 every 4 cycles. seg values are 0110000, 0100100, 1111001 for the first three, then 1111111 (blank) at an=0111.
5. Overrun: during SHIFT, pulse d_ready with 0x010 then 0x064 → overrun=1; the next conversion gives bcd=16'h0100; the 0x010 sample is never output.
6. Async reset mid-SHIFT: rst_l=0 → outputs return to reset values in the same cycle, no bcd_valid follows. A post-reset sample of 0x000 gives bcd=0.

Source files
------------

// File: rtl/spi_disp_pkg.sv
// Shared types and constants for the SPI sample display: converter FSM states
// and active-low 7-segment patterns for a 4-digit common-anode display.
package spi_disp_pkg;

  localparam int NUM_DIGITS = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } conv_state_t;

  // Segment order {g,f,e,d,c,b,a}, active-low; entry i holds digit i.
  localparam logic [9:0][6:0] SEG_DIGITS = {
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    if (nib <= 4'd9) return SEG_DIGITS[nib];
    return SEG_DASH;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: converts a SAMPLE_W-bit binary value into four BCD
// digits, one shift per cycle, with a start/done handshake.
module bin2bcd_seq
  import spi_disp_pkg::*;
#(
  parameter int SAMPLE_W = 12
) (
  input  logic                clk,
  input  logic                rst_l,
  input  logic                start,
  input  logic [SAMPLE_W-1:0] bin,
  output logic                ready,
  output logic [15:0]         result,
  output logic                done
);

  localparam int                CNT_W = $clog2(SAMPLE_W + 1);
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(SAMPLE_W - 1);

  conv_state_t         state;
  logic [15:0]         acc;
  logic [15:0]         acc_adj;
  logic [SAMPLE_W-1:0] sr;
  logic [CNT_W-1:0]    cnt;
  logic                unused_msb;

  // NOTE: every variable gets a default before the conditional updates so no latch is inferred.
  always_comb begin
    acc_adj = acc;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (acc[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
    end
  end

  // The result fits four digits, so the adjusted top bit is shifted out unused.
  assign unused_msb = acc_adj[15];
  assign ready      = (state == ST_IDLE);

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state  <= ST_IDLE;
      acc    <= '0;
      sr     <= '0;
      cnt    <= '0;
      result <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            acc   <= '0;
            sr    <= bin;
            cnt   <= '0;
            state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          {acc, sr} <= {acc_adj[14:0], sr, 1'b0};
          cnt       <= cnt + CNT_W'(1);
          if (cnt == LAST) state <= ST_DONE;
        end
        ST_DONE: begin
          result <= acc;
          done   <= 1'b1;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/spi_sample_display.sv
// Captures SPI words flagged by d_ready, converts the sample field to BCD and
// scans the result onto a multiplexed 4-digit common-anode 7-segment display.
module spi_sample_display
  import spi_disp_pkg::*;
#(
  parameter int SAMPLE_W    = 12,
  parameter int REFRESH_DIV = 100_000,
  parameter bit BLANK_LZ    = 1'b1
) (
  input  logic        clk,
  input  logic        rst_l,
  input  logic [15:0] d,
  input  logic        d_ready,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic [15:0] bcd,
  output logic        bcd_valid,
  output logic        overrun
);

  localparam int               REF_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_DIV - 1);

  logic [2:0]          rdy_sync;
  logic                rdy_rise;
  logic [SAMPLE_W-1:0] pending;
  logic                pending_v;
  logic                conv_ready;
  logic                conv_start;
  logic                unused_hi;

  // Bits above the sample field carry status from the reader, not sample data.
  assign unused_hi = ^d[15:SAMPLE_W];

  // [0],[1] synchronize d_ready into clk; [2] remembers the previous level.
  assign rdy_rise   = rdy_sync[1] & ~rdy_sync[2];
  assign conv_start = pending_v & conv_ready;
  assign dp         = 1'b1;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      rdy_sync  <= '0;
      pending   <= '0;
      pending_v <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      rdy_sync <= {rdy_sync[1:0], d_ready};
      if (rdy_rise) begin
        // One-deep slot: the newest sample wins, losing an unconsumed one is flagged.
        pending   <= d[SAMPLE_W-1:0];
        pending_v <= 1'b1;
        if (pending_v && !conv_start) overrun <= 1'b1;
      end else if (conv_start) begin
        pending_v <= 1'b0;
      end
    end
  end

  bin2bcd_seq #(
    .SAMPLE_W(SAMPLE_W)
  ) u_conv (
    .clk    (clk),
    .rst_l  (rst_l),
    .start  (conv_start),
    .bin    (pending),
    .ready  (conv_ready),
    .result (bcd),
    .done   (bcd_valid)
  );

  logic [REF_W-1:0] ref_cnt;
  logic             ref_wrap;
  logic [1:0]       digit_sel;
  logic [1:0]       digit_nxt;
  logic [3:0]       nib_nxt;
  logic [6:0]       seg_nxt;

  assign ref_wrap  = (ref_cnt == REF_LAST);
  assign digit_nxt = ref_wrap ? digit_sel + 2'd1 : digit_sel;
  assign nib_nxt   = bcd[{digit_nxt, 2'b00} +: 4];

  always_comb begin
    seg_nxt = seg_decode(nib_nxt);
    if (BLANK_LZ && digit_nxt != 2'd0 && (bcd >> {digit_nxt, 2'b00}) == 16'd0) seg_nxt = SEG_BLANK;
  end

  // an/seg are registered from the next digit select so they switch together.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      ref_cnt   <= '0;
      digit_sel <= 2'd0;
      an        <= 4'b1110;
      seg       <= SEG_DIGITS[0];
    end else begin
      ref_cnt   <= ref_wrap ? '0 : ref_cnt + REF_W'(1);
      digit_sel <= digit_nxt;
      an        <= ~(4'b0001 << digit_nxt);
      seg       <= seg_nxt;
    end
  end

endmodule

// File: tb/tb_spi_sample_display.sv
// Randomized and directed bench for spi_sample_display against a transaction-level
// model of capture, conversion latency, overrun and display scanning.
`timescale 1ns/1ps
module tb_spi_sample_display;

  localparam int SW  = 12;
  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst_l = 1'b0;
  logic [15:0] d = '0;
  logic        d_ready = 1'b0;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic [15:0] bcd;
  logic        bcd_valid;
  logic        overrun;

  spi_sample_display #(
    .SAMPLE_W(SW),
    .REFRESH_DIV(DIV),
    .BLANK_LZ(1'b1)
  ) dut (
    .clk       (clk),
    .rst_l     (rst_l),
    .d         (d),
    .d_ready   (d_ready),
    .seg       (seg),
    .dp        (dp),
    .an        (an),
    .bcd       (bcd),
    .bcd_valid (bcd_valid),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [6:0] seg_ref [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic logic [6:0] disp_ref(input logic [15:0] val, input int k);
    int digit;
    digit = (int'(val) >> (4 * k)) & 15;
    if (k > 0 && (int'(val) >> (4 * k)) == 0) return 7'b1111111;
    if (digit > 9) return 7'b0111111;
    return seg_ref[digit];
  endfunction

  int          cyc = 0;
  bit          m_h1 = 0, m_h2 = 0, m_h3 = 0;
  bit          m_pend_v = 0;
  int          m_pend_val = 0;
  int          m_free = 0;
  bit          m_res_pend = 0;
  int          m_res_edge = 0;
  logic [15:0] m_res_val = '0;
  logic [15:0] m_bcd = '0;
  logic [15:0] m_bcd_before = '0;
  bit          m_valid = 0;
  bit          m_ovr = 0;
  int          m_n = 0;
  logic [3:0]  m_an = 4'b1110;
  logic [6:0]  m_seg = 7'b1000000;
  bit          m_load, m_cap;

  always @(posedge clk) begin
    cyc++;
    if (!rst_l) begin
      m_h1 = 0; m_h2 = 0; m_h3 = 0;
      m_pend_v = 0; m_pend_val = 0; m_free = 0; m_res_pend = 0;
      m_bcd = '0; m_valid = 0; m_ovr = 0; m_n = 0;
      m_an = 4'b1110; m_seg = 7'b1000000;
    end else begin
      m_bcd_before = m_bcd;
      m_load  = m_pend_v && (cyc >= m_free);
      m_cap   = m_h2 && !m_h3;   // d_ready rose two edges earlier
      m_valid = 0;
      if (m_res_pend && cyc == m_res_edge) begin
        m_bcd = m_res_val; m_valid = 1; m_res_pend = 0;
      end
      if (m_load) begin
        m_res_pend = 1;
        m_res_edge = cyc + SW + 1;
        m_res_val  = to_bcd(m_pend_val);
        m_free     = cyc + SW + 2;
      end
      if (m_cap) begin
        if (m_pend_v && !m_load) m_ovr = 1;
        m_pend_v   = 1;
        m_pend_val = int'(d) & ((1 << SW) - 1);
      end else if (m_load) begin
        m_pend_v = 0;
      end
      m_h3 = m_h2; m_h2 = m_h1; m_h1 = d_ready;
      m_n++;
      m_an  = ~(4'b0001 << ((m_n / DIV) % 4));
      m_seg = disp_ref(m_bcd_before, (m_n / DIV) % 4);
    end
  end

  always @(negedge clk) begin
    if (!rst_l) begin
      check("rst_an", an, 4'b1110);
      check("rst_seg", seg, 7'b1000000);
      check("rst_dp", dp, 1'b1);
      check("rst_bcd", bcd, 16'h0000);
      check("rst_valid", bcd_valid, 1'b0);
      check("rst_overrun", overrun, 1'b0);
    end else begin
      check("bcd", bcd, m_bcd);
      check("bcd_valid", bcd_valid, m_valid);
      check("overrun", overrun, m_ovr);
      check("an", an, m_an);
      check("seg", seg, m_seg);
      check("dp", dp, 1'b1);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [15:0] v, input int hi, input int lo);
    d = v; d_ready = 1'b1;
    tick(hi);
    d_ready = 1'b0;
    tick(lo);
  endtask

  task automatic wait_valid(input string name, input int budget, output int at);
    int i;
    at = -1; i = 0;
    while (at < 0 && i < budget) begin
      @(negedge clk);
      if (bcd_valid) at = cyc;
      i++;
    end
    if (at < 0) check({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_an(input logic [3:0] target, input int budget);
    int i;
    i = 0;
    while (an !== target && i < budget) begin
      @(negedge clk);
      i++;
    end
    check("wait_an", an, target);
  endtask

  int         t0, at, nvalid;
  logic [3:0] an_exp [4];
  logic [6:0] sg_exp [4];

  initial begin
    // Reset state, then digit 0 shows "0" and leading digits are blank.
    tick(4);
    rst_l = 1'b1;
    check("rel_an", an, 4'b1110);
    check("rel_seg", seg, 7'b1000000);
    wait_an(4'b1101, 20); check("blank_d1", seg, 7'b1111111);
    wait_an(4'b1011, 20); check("blank_d2", seg, 7'b1111111);
    wait_an(4'b0111, 20); check("blank_d3", seg, 7'b1111111);
    wait_an(4'b1110, 20); check("zero_d0", seg, 7'b1000000);

    // Full-scale conversion and its latency.
    t0 = cyc + 1;
    send(16'h0FFF, 3, 2);
    wait_valid("conv_fff", 40, at);
    check("latency", 32'(at - t0 + 1), 32'd17);
    check("bcd_4095", bcd, 16'h4095);

    // Upper bits are ignored.
    send(16'hF07B, 3, 2);
    wait_valid("conv_07b", 40, at);
    check("bcd_0123", bcd, 16'h0123);

    // Scan of 0123 with leading-zero blanking.
    an_exp = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    sg_exp = '{7'b0110000, 7'b0100100, 7'b1111001, 7'b1111111};
    tick(2);
    wait_an(4'b1110, 20);
    for (int k = 0; k < 4; k++) begin
      check("scan_an", an, an_exp[k]);
      check("scan_seg", seg, sg_exp[k]);
      tick(DIV);
    end

    // Overrun: two samples arrive while 999 converts; only the newest is converted.
    send(16'h03E7, 3, 2);
    send(16'h0010, 3, 2);
    send(16'h0064, 3, 2);
    check("overrun_set", overrun, 1'b1);
    wait_valid("conv_999", 40, at);
    check("bcd_0999", bcd, 16'h0999);
    wait_valid("conv_100", 40, at);
    check("bcd_0100", bcd, 16'h0100);

    // Asynchronous reset during SHIFT.
    send(16'h0777, 3, 2);
    tick(3);
    @(posedge clk);
    #2 rst_l = 1'b0;
    #1;
    check("arst_bcd", bcd, 16'h0000);
    check("arst_overrun", overrun, 1'b0);
    check("arst_an", an, 4'b1110);
    check("arst_seg", seg, 7'b1000000);
    check("arst_valid", bcd_valid, 1'b0);
    tick(3);
    rst_l = 1'b1;
    nvalid = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bcd_valid) nvalid++;
    end
    check("no_valid_after_abort", 32'(nvalid), 32'd0);
    send(16'h0000, 3, 2);
    wait_valid("conv_000", 40, at);
    check("bcd_zero", bcd, 16'h0000);

    // Randomized traffic, checked every cycle against the model.
    for (int i = 0; i < 40; i++) begin
      send(16'($urandom), int'($urandom_range(5, 3)), int'($urandom_range(25, 2)));
    end
    tick(40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
